gray_counter_ext: RTL and testbench
===================================

# gray_counter_ext

Parametrised up/down Gray-code counter. It generalises the 3-bit up-only Gray counter to any width and adds:
- a direction control;
- a synchronous load of a Gray-coded value;
- selectable wrap or saturate behaviour;
- sticky overflow/underflow flags with a clear input;
- a terminal-count pulse.

It serves as the position/sequence counter in datapath and pointer logic where single-bit-change outputs are needed.

## Interface
- WIDTH, 3: counter width in bits; legal values 2..16.
- SATURATE, 0: 0 means the count wraps at the boundaries; 1 means it holds at the boundaries.
- Clk  in  1  rising-edge clock; the only clock.
- ResetN  in  1  asynchronous, active-low reset.
- En  in  1  count enable; one step per enabled cycle.
- Up  in  1  direction: 1 counts up, 0 counts down; sampled only when En=1.
- Load  in  1  synchronous load; has priority over En.
- LoadGray  in  WIDTH  value to load, Gray-coded.
- ClrFlag  in  1  synchronous clear of Overflow and Underflow.
- Output  out  WIDTH  current count, Gray-coded, registered.
- Binary  out  WIDTH  current count, binary, registered.
- Overflow  out  1  sticky flag: an up-step was attempted from 2^WIDTH-1.
- Underflow  out  1  sticky flag: a down-step was attempted from 0.
- Tc  out  1  one-cycle pulse on every boundary event.

## Operation
- State:
  - binary count register cnt, WIDTH bits;
  - Gray register g, always equal to cnt ^ (cnt >> 1);
  - flags Overflow and Underflow;
  - Tc register.
- Reset (ResetN=0, asynchronous, takes effect immediately regardless of Clk):
  - cnt=0, Output=0, Binary=0;
  - Overflow=0, Underflow=0, Tc=0.
- Per-edge priority, highest first:
  1. Load=1:
     - cnt is set to the Gray-to-binary conversion of LoadGray: bit i is the XOR of LoadGray[WIDTH-1:i];
     - En and Up are ignored;
     - no flag is set and Tc=0.
  2. En=1, Up=1, cnt<max:
     - cnt+1.
  3. En=1, Up=1, cnt=max (max = 2^WIDTH-1):
     - Overflow set to 1 and Tc=1;
     - cnt becomes 0 when SATURATE=0, or stays at max when SATURATE=1.
  4. En=1, Up=0, cnt>0:
     - cnt-1.
  5. En=1, Up=0, cnt=0:
     - Underflow set to 1 and Tc=1;
     - cnt becomes max when SATURATE=0, or stays at 0 when SATURATE=1.
  6. En=0:
     - cnt holds and Tc=0.
- Binary arithmetic is modulo 2^WIDTH. No carry is kept beyond WIDTH bits.
- Flags:
  - Once set, a flag stays at 1 until ClrFlag or reset.
  - ClrFlag=1 clears both flags on the edge.
  - If a boundary event occurs on the same edge as ClrFlag, the flag for that event is 1 after the edge. Set wins over clear. The other flag is cleared.
- Tc is 1 for exactly the cycle following an edge that recorded a boundary event. In saturate mode, repeated enabled steps at the boundary produce a Tc pulse on each of those edges.
- Output and Binary are driven directly from registers. There is no combinational path from any input to any output.
- Gray property: consecutive values of Output after a count step differ in exactly one bit, including across a wrap. Load and reset may change several bits.

## Timing
- Single clock domain, all updates on the rising edge of Clk. The only asynchronous path is the assertion of ResetN.
- ResetN deassertion is assumed to be synchronised externally. The first counting edge is the first rising edge with ResetN=1.
- Latency is 1 cycle from an input sampled at edge k to the output visible after edge k. Output, Binary, flags and Tc all update on the same edge.
- ResetN asserted mid-count forces every output to its reset value within the same cycle, with no clock needed. Counting resumes from 0.
- Load and En both high on the same edge: the loaded value is taken and no step is applied that cycle.

## Test plan
- Reset then count up (WIDTH=3, SATURATE=0): hold En=1, Up=1 for 9 edges.
  - Output must be 000,001,011,010,110,111,101,100,000.
  - On the 8th-to-9th step Overflow goes to 1 and Tc pulses exactly once.
  - Binary must track 0..7,0.
- Down wrap: from reset, one edge with En=1, Up=0.
  - Output=100, Binary=7, Underflow=1, Tc=1 for one cycle.
  - Overflow stays 0.
- Saturate (SATURATE=1): Load LoadGray=100 (binary 7), then 3 up-steps.
  - Binary stays at 7.
  - Tc pulses on each of the 3 edges; Overflow=1.
- Load priority and conversion (WIDTH=4):
  - Load=1, En=1, LoadGray=1101 gives Binary=1001, Output=1101, Tc=0.
  - Next edge with En=1, Up=1 gives Binary=1010, Output=1111.
- Flag clear race:
  - With Overflow=1, assert ClrFlag alone: Overflow goes to 0.
  - Then, at max, assert ClrFlag together with an up-step: Overflow ends at 1 and Underflow at 0.
- Asynchronous reset mid-count: pull ResetN low between edges while Binary=5.
  - All outputs go to 0 before the next Clk edge.
  - After release, counting restarts at 001.

Source files
------------

// File: rtl/gray_counter_ext.sv
// Parametrised up/down Gray-code counter with load, wrap/saturate boundary handling,
// sticky overflow/underflow flags and a terminal-count pulse. All outputs are registered.
module gray_counter_ext #(
    parameter int unsigned WIDTH    = 3,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadGray,
    input  logic             ClrFlag,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Tc
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             tc_q, tc_d;

    // Binary bit i is the XOR of all Gray bits from the MSB down to i.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no branch can infer a latch.
        cnt_d       = cnt_q;
        overflow_d  = ClrFlag ? 1'b0 : overflow_q;
        underflow_d = ClrFlag ? 1'b0 : underflow_q;
        tc_d        = 1'b0;

        if (Load) begin
            cnt_d = gray_to_bin(LoadGray);
        end else if (En) begin
            if (Up) begin
                if (cnt_q == MAX) begin
                    overflow_d = 1'b1;
                    tc_d       = 1'b1;
                    cnt_d      = SATURATE ? MAX : '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    underflow_d = 1'b1;
                    tc_d        = 1'b1;
                    cnt_d       = SATURATE ? '0 : MAX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end

        // Gray is registered alongside the binary count so Output never glitches.
        gray_d = cnt_d ^ (cnt_d >> 1);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            cnt_q       <= '0;
            gray_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            tc_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            gray_q      <= gray_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            tc_q        <= tc_d;
        end
    end

    assign Output    = gray_q;
    assign Binary    = cnt_q;
    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;
    assign Tc        = tc_q;

endmodule

// File: tb/tb_gray_counter_ext.sv
// Bench for gray_counter_ext: three instances (3-bit wrap, 3-bit saturate, 4-bit wrap)
// share one stimulus stream and are compared against an arithmetic reference model.
module tb_gray_counter_ext;

    logic       Clk = 1'b0;
    logic       ResetN;
    logic       En;
    logic       Up;
    logic       Load;
    logic [3:0] LoadGray;
    logic       ClrFlag;

    logic [2:0] w3_g, w3_b, s3_g, s3_b;
    logic [3:0] w4_g, w4_b;
    logic       w3_ovf, w3_unf, w3_tc;
    logic       s3_ovf, s3_unf, s3_tc;
    logic       w4_ovf, w4_unf, w4_tc;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state, one slot per instance.
    int       m_cnt [3];
    bit       m_ovf [3];
    bit       m_unf [3];
    bit       m_tc  [3];
    const int M_W   [3] = '{3, 3, 4};
    const bit M_SAT [3] = '{1'b0, 1'b1, 1'b0};
    string    names [3] = '{"wrap3", "sat3", "wrap4"};

    gray_counter_ext #(.WIDTH(3), .SATURATE(1'b0)) u_wrap3 (
        .Clk(Clk), .ResetN(ResetN), .En(En), .Up(Up), .Load(Load),
        .LoadGray(LoadGray[2:0]), .ClrFlag(ClrFlag), .Output(w3_g), .Binary(w3_b),
        .Overflow(w3_ovf), .Underflow(w3_unf), .Tc(w3_tc)
    );

    gray_counter_ext #(.WIDTH(3), .SATURATE(1'b1)) u_sat3 (
        .Clk(Clk), .ResetN(ResetN), .En(En), .Up(Up), .Load(Load),
        .LoadGray(LoadGray[2:0]), .ClrFlag(ClrFlag), .Output(s3_g), .Binary(s3_b),
        .Overflow(s3_ovf), .Underflow(s3_unf), .Tc(s3_tc)
    );

    gray_counter_ext #(.WIDTH(4), .SATURATE(1'b0)) u_wrap4 (
        .Clk(Clk), .ResetN(ResetN), .En(En), .Up(Up), .Load(Load),
        .LoadGray(LoadGray), .ClrFlag(ClrFlag), .Output(w4_g), .Binary(w4_b),
        .Overflow(w4_ovf), .Underflow(w4_unf), .Tc(w4_tc)
    );

    initial forever #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int to_gray(input int v);
        return v ^ (v >> 1);
    endfunction

    // Decode by search: the binary value whose Gray image equals g.
    function automatic int from_gray(input int g, input int w);
        for (int v = 0; v < (1 << w); v++) begin
            if (to_gray(v) == g) return v;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_tc[i] = 0;
        end
    endtask

    // Applies one rising edge of the behavioural rules to every model slot.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int  max_v;
            bit  ev_o, ev_u;
            max_v = (1 << M_W[i]) - 1;
            ev_o  = 0;
            ev_u  = 0;
            if (!ResetN) begin
                m_cnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_tc[i] = 0;
            end else begin
                if (Load) begin
                    m_cnt[i] = from_gray(int'(LoadGray) & max_v, M_W[i]);
                end else if (En && Up) begin
                    if (m_cnt[i] < max_v) m_cnt[i] = m_cnt[i] + 1;
                    else begin ev_o = 1; m_cnt[i] = M_SAT[i] ? max_v : 0; end
                end else if (En) begin
                    if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                    else begin ev_u = 1; m_cnt[i] = M_SAT[i] ? 0 : max_v; end
                end
                m_tc[i]  = ev_o | ev_u;
                m_ovf[i] = ev_o ? 1'b1 : (ClrFlag ? 1'b0 : m_ovf[i]);
                m_unf[i] = ev_u ? 1'b1 : (ClrFlag ? 1'b0 : m_unf[i]);
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] og, ob;
            logic        oo, ou, ot;
            case (i)
                0:       begin og = 16'(w3_g); ob = 16'(w3_b); oo = w3_ovf; ou = w3_unf; ot = w3_tc; end
                1:       begin og = 16'(s3_g); ob = 16'(s3_b); oo = s3_ovf; ou = s3_unf; ot = s3_tc; end
                default: begin og = 16'(w4_g); ob = 16'(w4_b); oo = w4_ovf; ou = w4_unf; ot = w4_tc; end
            endcase
            check({tag, ".", names[i], ".gray"}, og, 16'(to_gray(m_cnt[i])));
            check({tag, ".", names[i], ".bin"},  ob, 16'(m_cnt[i]));
            check({tag, ".", names[i], ".ovf"},  16'(oo), 16'(m_ovf[i]));
            check({tag, ".", names[i], ".unf"},  16'(ou), 16'(m_unf[i]));
            check({tag, ".", names[i], ".tc"},   16'(ot), 16'(m_tc[i]));
        end
    endtask

    // Drive inputs at the falling edge, advance one rising edge, return at the next falling edge.
    task automatic step(input bit en, input bit up, input bit ld, input logic [3:0] lg, input bit clr);
        En = en; Up = up; Load = ld; LoadGray = lg; ClrFlag = clr;
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        En = 0; Up = 0; Load = 0; ClrFlag = 0;
    endtask

    task automatic do_reset();
        ResetN = 0;
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        ResetN = 1;
    endtask

    initial begin
        logic [2:0] up_gray [8];
        up_gray = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

        ResetN = 0; En = 0; Up = 0; Load = 0; LoadGray = '0; ClrFlag = 0;
        model_reset();
        repeat (2) @(negedge Clk);
        check_all("reset");
        ResetN = 1;

        // Count up through a full 3-bit wrap.
        for (int k = 0; k < 8; k++) begin
            step(1, 1, 0, 4'h0, 0);
            check_all("up");
            check($sformatf("up_seq%0d.gray", k), 16'(w3_g), 16'(up_gray[k]));
            check($sformatf("up_seq%0d.bin", k), 16'(w3_b), 16'((k + 1) % 8));
        end
        check("up_wrap.ovf", 16'(w3_ovf), 16'd1);
        check("up_wrap.tc", 16'(w3_tc), 16'd1);
        step(1, 1, 0, 4'h0, 0);
        check_all("up_after");
        check("up_after.tc", 16'(w3_tc), 16'd0);
        check("up_after.ovf", 16'(w3_ovf), 16'd1);

        // Down-step from zero.
        do_reset();
        step(1, 0, 0, 4'h0, 0);
        check_all("down_wrap");
        check("down_wrap.gray", 16'(w3_g), 16'b100);
        check("down_wrap.bin", 16'(w3_b), 16'd7);
        check("down_wrap.unf", 16'(w3_unf), 16'd1);
        check("down_wrap.tc", 16'(w3_tc), 16'd1);
        check("down_wrap.ovf", 16'(w3_ovf), 16'd0);
        step(0, 0, 0, 4'h0, 0);
        check_all("down_idle");
        check("down_idle.tc", 16'(w3_tc), 16'd0);

        // Saturate at max: load Gray 100, then three up-steps.
        step(0, 0, 1, 4'b0100, 0);
        check_all("sat_load");
        check("sat_load.bin", 16'(s3_b), 16'd7);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 4'h0, 0);
            check_all("sat_up");
            check($sformatf("sat_up%0d.bin", k), 16'(s3_b), 16'd7);
            check($sformatf("sat_up%0d.tc", k), 16'(s3_tc), 16'd1);
            check($sformatf("sat_up%0d.ovf", k), 16'(s3_ovf), 16'd1);
        end

        // Load beats En; 4-bit conversion.
        step(1, 1, 1, 4'b1101, 0);
        check_all("load_pri");
        check("load_pri.bin", 16'(w4_b), 16'b1001);
        check("load_pri.gray", 16'(w4_g), 16'b1101);
        check("load_pri.tc", 16'(w4_tc), 16'd0);
        step(1, 1, 0, 4'h0, 0);
        check_all("load_next");
        check("load_next.bin", 16'(w4_b), 16'b1010);
        check("load_next.gray", 16'(w4_g), 16'b1111);

        // Flag clear, then set-wins-over-clear at max.
        step(0, 0, 0, 4'h0, 1);
        check_all("clr_alone");
        check("clr_alone.ovf", 16'(s3_ovf), 16'd0);
        step(0, 0, 1, 4'b0000, 0);
        step(1, 0, 0, 4'h0, 0);
        check_all("pre_race");
        check("pre_race.unf", 16'(s3_unf), 16'd1);
        step(0, 0, 1, 4'b0100, 0);
        step(1, 1, 0, 4'h0, 1);
        check_all("clr_race");
        check("clr_race.ovf", 16'(s3_ovf), 16'd1);
        check("clr_race.unf", 16'(s3_unf), 16'd0);
        check("clr_race.tc", 16'(s3_tc), 16'd1);

        // Asynchronous reset between edges.
        do_reset();
        repeat (5) step(1, 1, 0, 4'h0, 0);
        check("async_pre.bin", 16'(w3_b), 16'd5);
        #2 ResetN = 0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst.gray", 16'(w3_g), 16'd0);
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        ResetN = 1;
        step(1, 1, 0, 4'h0, 0);
        check_all("async_resume");
        check("async_resume.gray", 16'(w3_g), 16'b001);

        // Randomised traffic.
        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 15) == 0);
            check_all($sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
